// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//
// Multi-cycle data-memory target for the CPU MEM stage. A request seen in IDLE
// is latched, held in BUSY for LATENCY cycles, committed on the last BUSY edge,
// and acknowledged with a one-cycle ack_o pulse in DONE. stall_o freezes the
// upstream pipeline registers while an access is in flight.
//
// Parameters:
//   DEPTH    number of 32-bit words (power of 2)
//   ADDR_W   log2(DEPTH); word index = addr_i[ADDR_W+1:2]
//   LATENCY  cycles spent in BUSY per access (>= 1)
//
// Ports:
//   clk_i       rising-edge clock
//   rst_n_i     asynchronous active-low reset
//   MemRead_i   load request
//   MemWrite_i  store request (wins when both are high)
//   addr_i      byte address
//   data_i      store data
//   data_o      registered load data, valid with ack_o
//   stall_o     combinational pipeline freeze
//   ack_o       one-cycle completion pulse
//   err_o       access error pulse, coincident with ack_o
//
// Build option:
//   DMEM_ERR_EN  when defined, misaligned or out-of-range addresses flag
//                err_o, suppress the store and return zero on a load. When
//                undefined, err_o stays 0, addr_i[1:0] is ignored and the
//                address wraps modulo DEPTH*4.
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       data_q, data_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;

    logic              req;
    logic              stall;
    logic              commit;
    logic              acc_err;
    logic [ADDR_W-1:0] idx;

    logic [31:0]       mem [DEPTH];

    assign req = MemRead_i | MemWrite_i;
    assign idx = addr_q[ADDR_W+1:2];

`ifdef DMEM_ERR_EN
    // Judged on the latched address so mid-access input changes cannot matter.
    assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q >= 32'(DEPTH * 4));
`else
    logic unused_addr_bits;
    assign acc_err          = 1'b0;
    assign unused_addr_bits = ^{addr_q[31:ADDR_W+2], addr_q[1:0]};
`endif

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        stall   = 1'b0;
        commit  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    // Stall in the request cycle itself so EX_MEM holds still.
                    stall   = 1'b1;
                    write_d = MemWrite_i;
                    addr_d  = addr_i;
                    wdata_d = data_i;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                stall = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    commit = 1'b1;
                    if (!write_q) begin
                        data_d = acc_err ? 32'h0 : mem[idx];
                    end
                    ack_d   = 1'b1;
                    err_d   = acc_err;
                    state_d = StDone;
                end
            end
            StDone: begin
                // Request still visible here is the one just served; never re-accept it.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Reset must release the pipeline even while a request is still presented.
    assign stall_o = stall & rst_n_i;
    assign data_o  = data_q;
    assign ack_o   = ack_q;
    assign err_o   = err_q;

    // ------------------------------------------------------------------
    // Control and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            data_q  <= 32'h0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset. A reset before the commit edge leaves state_q in
    // IDLE, so an aborted store never reaches the array.
    always_ff @(posedge clk_i) begin
        if (commit && write_q && !acc_err) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int unsigned DEPTH   = 32;
    localparam int unsigned LATENCY = 2;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dout;
    logic        stall;
    logic        ack;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    dmem_responder #(
        .DEPTH  (DEPTH),
        .ADDR_W (5),
        .LATENCY(LATENCY)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .MemRead_i (mem_read),
        .MemWrite_i(mem_write),
        .addr_i    (addr),
        .data_i    (wdata),
        .data_o    (dout),
        .stall_o   (stall),
        .ack_o     (ack),
        .err_o     (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Present a request from the start of a cycle, follow it to its ack and
    // check stall length, ack data and error flag. Inputs stay held through
    // DONE, so consecutive calls form back-to-back accesses.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp_data,
                             input bit scramble, output int ack_cyc);
        int  n_stall;
        bit  got;
        @(posedge clk);
        #1;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        n_stall   = 0;
        got       = 1'b0;
        ack_cyc   = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                break;
            end
            n_stall++;
            check("stall_in_flight", 32'(stall), 32'd1);
            // Latched values only: garble inputs once the request is taken.
            if (scramble && c >= 1) begin
                mem_read  = 1'($urandom);
                mem_write = 1'($urandom);
                addr      = $urandom;
                wdata     = $urandom;
            end
        end
        check("ack_seen", 32'(got), 32'd1);
        check("stall_cycles", 32'(n_stall), 32'(LATENCY + 1));
        if (got) begin
            ack_cyc = cyc;
            check("ack_data", dout, exp_data);
            check("stall_in_done", 32'(stall), 32'd0);
            check("err_in_done", 32'(err), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            @(negedge clk);
            check("idle_stall", 32'(stall), 32'd0);
            check("idle_ack", 32'(ack), 32'd0);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[9];
    logic [31:0] mem_m[DEPTH];
    logic [31:0] last;
    int          ack_a;
    int          ack_b;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h1111_1111};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        tbl[2] = '{1'b1, 1'b1, 32'h0000_0000, 32'h1234_5678, 32'hDEAD_BEEF};
        tbl[3] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h1234_5678};
        tbl[4] = '{1'b0, 1'b1, 32'h0000_0084, 32'hA5A5_A5A5, 32'h1234_5678};
        tbl[5] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'hA5A5_A5A5};
        tbl[6] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF};
        tbl[7] = '{1'b0, 1'b1, 32'hFFFF_FF80, 32'h0BAD_F00D, 32'hDEAD_BEEF};
        tbl[8] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0BAD_F00D};

        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", dout, 32'h0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of a store aborts it.
        do_access(1'b0, 1'b1, 32'h8, 32'h1111_1111, 32'h0, 1'b0, ack_a);
        do_access(1'b1, 1'b0, 32'h8, 32'h0, 32'h1111_1111, 1'b0, ack_a);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b1;
        addr      = 32'h8;
        wdata     = 32'h2222_2222;
        @(negedge clk);
        check("abort_req_stall", 32'(stall), 32'd1);
        @(negedge clk);
        check("abort_busy_stall", 32'(stall), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_data", dout, 32'h0);
        check("abort_stall", 32'(stall), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        mem_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        do_access(1'b1, 1'b0, 32'h8, 32'h0, 32'h1111_1111, 1'b0, ack_a);

        // Directed vectors, issued back to back.
        for (int i = 0; i < 9; i++) begin
            do_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].exp, 1'b0, ack_a);
        end
        idle(2);

        // Store then load with requests held continuously.
        do_access(1'b0, 1'b1, 32'h4, 32'h5555_AAAA, 32'h0BAD_F00D, 1'b0, ack_a);
        do_access(1'b1, 1'b0, 32'h4, 32'h0, 32'h5555_AAAA, 1'b0, ack_b);
        check("b2b_ack_gap", 32'(ack_b - ack_a), 32'(LATENCY + 2));
        idle(3);
        last = 32'h5555_AAAA;

        // Randomized phase against a word-array model.
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = $urandom;
            do_access(1'b0, 1'b1, 32'(i * 4), mem_m[i], last, 1'b0, ack_a);
        end
        for (int n = 0; n < 80; n++) begin
            int unsigned op;
            int unsigned wi;
            logic [31:0] a;
            logic [31:0] d;
            op = $urandom_range(0, 2);
            a  = $urandom;
            d  = $urandom;
            wi = (a / 4) % DEPTH;
            if (op != 0) mem_m[wi] = d;
            else         last = mem_m[wi];
            do_access(op != 1, op != 0, a, d, last, 1'($urandom), ack_a);
            idle(int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
